jam_cost_table: RTL and testbench
=================================

Name: jam_cost_table

Overview:
- Upstream cost source for the job-assignment engine.
- Accepts an N x N cost matrix over a valid/ready load stream, row-major: worker-major, job-minor.
- Serves Cost for the engine's W/J address pair with zero read latency.
- Tracks two load-side figures:
  - LB_SUM: sum of per-row minima, a lower bound on any assignment's cost. The engine uses it for early exit and sanity checks.
  - TOTAL_SUM: checksum of all entries.
- Asserts TABLE_READY once a complete matrix is held; TABLE_READY gates the engine's start.

Parameters:
- N, 8, workers = jobs. Power of 2, 2..8.
- CW, 7, cost entry width in bits.
- Derived, not overridable:
  - AW = 2*log2(N), load index width.
  - LBW = CW + log2(N), LB_SUM width.
  - TSW = CW + 2*log2(N), TOTAL_SUM width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- LD_VALID  in  1  load data valid.
- LD_DATA  in  CW  cost entry.
- LD_READY  out  1  table accepts entries.
- RELOAD  in  1  single-cycle pulse; restart load from entry 0.
- W  in  log2(N)  worker index from engine.
- J  in  log2(N)  job index from engine.
- Cost  out  CW  cost[W][J].
- TABLE_READY  out  1  complete matrix loaded.
- LB_SUM  out  LBW  sum of row minima.
- TOTAL_SUM  out  TSW  sum of all entries.
- LOAD_IDX  out  AW  next entry index (debug).

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = LOAD; idx = 0; TABLE_READY = 0; LB_SUM = 0; TOTAL_SUM = 0; row_min = all ones.
  - Storage array is not reset.
- Two states: LOAD, DONE.
- LD_READY = (state == LOAD), combinational from the state register.
- Handshake: an entry is accepted on a rising edge with LD_VALID & LD_READY & !RELOAD.
  - mem[idx] <= LD_DATA; idx <= idx + 1.
  - LD_DATA is ignored when not accepted.
- Row tracking on each accepted entry, with column = idx[log2(N)-1:0]:
  - Column 0: row_min <= LD_DATA.
  - Other columns: row_min <= min(row_min, LD_DATA).
  - Column N-1: LB_SUM <= LB_SUM + min(row_min, LD_DATA). Comparison is unsigned.
  - Every accepted entry: TOTAL_SUM <= TOTAL_SUM + LD_DATA.
  - No overflow possible at the declared widths.
- LOAD -> DONE on acceptance of entry N*N-1.
  - idx wraps to 0.
  - TABLE_READY = 1 from the following cycle.
  - LB_SUM and TOTAL_SUM are final in that same cycle.
- DONE:
  - LD_READY = 0; LD_VALID is ignored.
  - Sums and memory are held.
- RELOAD, in either state:
  - Next cycle: state = LOAD, idx = 0, LB_SUM = 0, TOTAL_SUM = 0, TABLE_READY = 0.
  - Memory keeps its old contents until overwritten.
  - RELOAD has priority over a coincident handshake; that entry is discarded and not counted.
- Read path:
  - Cost = TABLE_READY ? mem[{W,J}] : 0.
  - Combinational, same cycle as W/J; the engine samples Cost in the cycle it drives W/J.
  - No write-read hazard, because reads are gated by TABLE_READY.
- RST_N asserted mid-load: all load progress is lost and the next entry accepted is entry 0.
- All outputs are glitch-free registers except Cost and LD_READY.

Decomposition:
- Shared package jam_pkg holds:
  - N_JOBS = 8 and COST_W = 7, shared with the assignment engine.
  - Enum jam_tbl_state_e {LOAD, DONE}.
  - Derived widths AW, LBW, TSW.
- One sub-module: jam_row_min.
  - Function: running-minimum register plus LB accumulator, driven by accept/column strobes.
  - Reusable for a column-minimum bound later.
- The storage array stays in the top as a register array.

Test Plan:
- Default load, mem[w][j] = 8w+j, with no LD_VALID gaps:
  - LD_READY stays high for 64 cycles, then drops.
  - TABLE_READY = 1 the cycle after the 64th acceptance.
  - LB_SUM = 224, TOTAL_SUM = 2016, and Cost at W=5, J=3 is 43.
- Same data with random LD_VALID gaps and Cost read mid-load:
  - Cost = 0 while loading.
  - Final sums match the first scenario: LB_SUM = 224, TOTAL_SUM = 2016.
- All entries 127:
  - LB_SUM = 1016, TOTAL_SUM = 8128.
  - Cost = 127 at every W/J.
- RELOAD after 10 entries, then a full load of the 8x8 matrix with row w = {7-w repeated}:
  - LB_SUM = 28, TOTAL_SUM = 224.
  - LOAD_IDX returns to 0 the cycle after RELOAD.
- RELOAD coincident with a handshake in DONE:
  - Entry discarded, LOAD_IDX = 0, TABLE_READY falls next cycle.
  - After a fresh full load, sums reflect only the new data.
- RST_N pulsed low for half a cycle at entry 40:
  - TABLE_READY = 0, sums = 0, LOAD_IDX = 0 immediately.
  - After that, 64 further entries are required before TABLE_READY rises.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared constants and types for the job-assignment cost table and engine.
// Widths below are derived from N_JOBS and COST_W.
package jam_pkg;

    localparam int N_JOBS = 8;
    localparam int COST_W = 7;

    localparam int AW  = 2 * $clog2(N_JOBS);
    localparam int LBW = COST_W + $clog2(N_JOBS);
    localparam int TSW = COST_W + 2 * $clog2(N_JOBS);

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } jam_tbl_state_e;

endpackage

// File: rtl/jam_row_min.sv
// Running minimum over a stream of row entries, folded into a sum of minima
// at each row's last column. Row/column orientation is set by the strobes.
module jam_row_min #(
    parameter int CW = 7,
    parameter int SW = 10
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr,
    input  logic          acc,
    input  logic          col_first,
    input  logic          col_last,
    input  logic [CW-1:0] din,
    output logic [SW-1:0] lb_sum
);

    logic [CW-1:0] row_min;
    logic [CW-1:0] cand;

    // First column restarts the minimum regardless of the stale value.
    assign cand = (col_first || (din < row_min)) ? din : row_min;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_min <= '1;
            lb_sum  <= '0;
        end else if (clr) begin
            row_min <= '1;
            lb_sum  <= '0;
        end else if (acc) begin
            row_min <= cand;
            if (col_last)
                lb_sum <= lb_sum + SW'(cand);
        end
    end

endmodule

// File: rtl/jam_cost_table.sv
// N x N cost matrix loaded row-major over valid/ready; serves cost[W][J]
// combinationally once complete, with lower-bound and checksum side figures.
module jam_cost_table
    import jam_pkg::*;
#(
    parameter  int N     = N_JOBS,
    parameter  int CW    = COST_W,
    localparam int LG    = $clog2(N),
    localparam int IDX_W = 2 * LG,
    localparam int LB_W  = CW + LG,
    localparam int TS_W  = CW + 2 * LG
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LD_VALID,
    input  logic [CW-1:0]    LD_DATA,
    output logic             LD_READY,
    input  logic             RELOAD,
    input  logic [LG-1:0]    W,
    input  logic [LG-1:0]    J,
    output logic [CW-1:0]    Cost,
    output logic             TABLE_READY,
    output logic [LB_W-1:0]  LB_SUM,
    output logic [TS_W-1:0]  TOTAL_SUM,
    output logic [IDX_W-1:0] LOAD_IDX
);

    jam_tbl_state_e   state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [CW-1:0]    mem [N*N];
    logic             accept;
    logic             last;

    assign accept = LD_VALID && LD_READY && !RELOAD;
    assign last   = (idx == IDX_W'(N*N-1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= LOAD;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        LD_READY = (state == LOAD);
        if (RELOAD)
            state_nx = LOAD;
        else if (accept && last)
            state_nx = DONE;
    end

    // idx is exactly log2(N*N) bits, so the increment past the last entry wraps to 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx         <= '0;
            TABLE_READY <= 1'b0;
            TOTAL_SUM   <= '0;
        end else if (RELOAD) begin
            idx         <= '0;
            TABLE_READY <= 1'b0;
            TOTAL_SUM   <= '0;
        end else if (accept) begin
            idx       <= idx + 1'b1;
            TOTAL_SUM <= TOTAL_SUM + TS_W'(LD_DATA);
            if (last)
                TABLE_READY <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept)
            mem[idx] <= LD_DATA;
    end

    jam_row_min #(
        .CW (CW),
        .SW (LB_W)
    ) u_row_min (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clr       (RELOAD),
        .acc       (accept),
        .col_first (idx[LG-1:0] == '0),
        .col_last  (idx[LG-1:0] == LG'(N-1)),
        .din       (LD_DATA),
        .lb_sum    (LB_SUM)
    );

    assign Cost     = TABLE_READY ? mem[{W, J}] : '0;
    assign LOAD_IDX = idx;

endmodule

// File: tb/tb_jam_cost_table.sv
// Randomized and directed bench for jam_cost_table against a queue-based
// model: the accepted-entry list determines index, sums, readiness and contents.
module tb_jam_cost_table;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LD_VALID = 1'b0;
    logic       RELOAD = 1'b0;
    logic [6:0] LD_DATA = '0;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic       LD_READY;
    logic       TABLE_READY;
    logic [6:0] Cost;
    logic [9:0] LB_SUM;
    logic [12:0] TOTAL_SUM;
    logic [5:0] LOAD_IDX;

    int total = 0;
    int bad = 0;
    int ld_q[$];
    int mmem[64];
    bit exp_done = 1'b0;

    jam_cost_table dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .LD_VALID    (LD_VALID),
        .LD_DATA     (LD_DATA),
        .LD_READY    (LD_READY),
        .RELOAD      (RELOAD),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .TABLE_READY (TABLE_READY),
        .LB_SUM      (LB_SUM),
        .TOTAL_SUM   (TOTAL_SUM),
        .LOAD_IDX    (LOAD_IDX)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sum of minima over every complete row received so far.
    function automatic int exp_lb();
        int s;
        int m;
        s = 0;
        for (int r = 0; r < ld_q.size() / 8; r++) begin
            m = ld_q[r*8];
            for (int c = 1; c < 8; c++)
                if (ld_q[r*8+c] < m) m = ld_q[r*8+c];
            s += m;
        end
        return s;
    endfunction

    function automatic int exp_ts();
        int s;
        s = 0;
        foreach (ld_q[i]) s += ld_q[i];
        return s;
    endfunction

    task automatic check_all();
        int ec;
        chk("ld_ready", 32'(LD_READY), 32'(!exp_done));
        chk("table_ready", 32'(TABLE_READY), 32'(exp_done));
        chk("load_idx", 32'(LOAD_IDX), exp_done ? 0 : ld_q.size());
        chk("lb_sum", 32'(LB_SUM), exp_lb());
        chk("total_sum", 32'(TOTAL_SUM), exp_ts());
        W = 3'($urandom_range(0, 7));
        J = 3'($urandom_range(0, 7));
        #1;
        ec = exp_done ? mmem[int'(W)*8 + int'(J)] : 0;
        chk("cost", 32'(Cost), ec);
    endtask

    // One clock edge with the currently driven inputs, model update, then checks.
    task automatic tick();
        @(posedge CLK);
        if (RELOAD) begin
            ld_q.delete();
            exp_done = 1'b0;
        end else if (LD_VALID && !exp_done) begin
            mmem[ld_q.size()] = int'(LD_DATA);
            ld_q.push_back(int'(LD_DATA));
            if (ld_q.size() == 64) exp_done = 1'b1;
        end
        @(negedge CLK);
        check_all();
    endtask

    task automatic pulse_reload();
        RELOAD = 1'b1;
        tick();
        RELOAD = 1'b0;
    endtask

    // kind: 0 = 8w+j, 1 = all 127, 2 = row w holds 7-w, 3 = random
    task automatic load_seq(input int kind, input bit gaps);
        int cyc;
        int k;
        cyc = 0;
        while (!exp_done && cyc < 2000) begin
            k = ld_q.size();
            case (kind)
                0:       LD_DATA = 7'(k);
                1:       LD_DATA = 7'd127;
                2:       LD_DATA = 7'(7 - k / 8);
                default: LD_DATA = 7'($urandom_range(0, 127));
            endcase
            LD_VALID = 1'b1;
            if (gaps && $urandom_range(0, 2) == 0) begin
                LD_VALID = 1'b0;
                LD_DATA  = 7'($urandom_range(0, 127));
            end
            tick();
            cyc++;
        end
        if (!exp_done) chk("load_timeout", 32'(0), 32'(1));
        LD_VALID = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_ld_ready", 32'(LD_READY), 32'(1));
        chk("rst_table_ready", 32'(TABLE_READY), 32'(0));
        chk("rst_lb", 32'(LB_SUM), 32'(0));
        chk("rst_total", 32'(TOTAL_SUM), 32'(0));
        chk("rst_idx", 32'(LOAD_IDX), 32'(0));
        chk("rst_cost", 32'(Cost), 32'(0));
        RST_N = 1'b1;

        // Gap-free default matrix, then extra cycles in DONE with valid held high
        load_seq(0, 1'b0);
        chk("s1_lb", 32'(LB_SUM), 32'(224));
        chk("s1_total", 32'(TOTAL_SUM), 32'(2016));
        W = 3'd5; J = 3'd3; #1;
        chk("s1_cost53", 32'(Cost), 32'(43));
        LD_VALID = 1'b1;
        LD_DATA  = 7'd99;
        repeat (3) tick();
        LD_VALID = 1'b0;

        // Same data with random valid gaps
        pulse_reload();
        load_seq(0, 1'b1);
        chk("s2_lb", 32'(LB_SUM), 32'(224));
        chk("s2_total", 32'(TOTAL_SUM), 32'(2016));

        // All maximum entries
        pulse_reload();
        load_seq(1, 1'b1);
        chk("s3_lb", 32'(LB_SUM), 32'(1016));
        chk("s3_total", 32'(TOTAL_SUM), 32'(8128));
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) begin
                W = 3'(w); J = 3'(j); #1;
                chk("s3_cost", 32'(Cost), 32'(127));
            end

        // Abort a partial load after 10 entries, then rows of 7-w
        pulse_reload();
        for (int i = 0; i < 10; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 7'($urandom_range(0, 127));
            tick();
        end
        LD_VALID = 1'b0;
        pulse_reload();
        chk("s4_idx_after_reload", 32'(LOAD_IDX), 32'(0));
        load_seq(2, 1'b1);
        chk("s4_lb", 32'(LB_SUM), 32'(28));
        chk("s4_total", 32'(TOTAL_SUM), 32'(224));

        // RELOAD coincident with a handshake attempt in DONE, then fresh random load
        LD_VALID = 1'b1;
        LD_DATA  = 7'd55;
        pulse_reload();
        LD_VALID = 1'b0;
        chk("s5_idx", 32'(LOAD_IDX), 32'(0));
        chk("s5_table_ready", 32'(TABLE_READY), 32'(0));
        chk("s5_total", 32'(TOTAL_SUM), 32'(0));
        load_seq(3, 1'b1);

        // Asynchronous reset mid-load at entry 40
        pulse_reload();
        for (int i = 0; i < 40; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 7'($urandom_range(1, 127));
            tick();
        end
        LD_VALID = 1'b0;
        RST_N = 1'b0;
        #1;
        ld_q.delete();
        exp_done = 1'b0;
        chk("s6_table_ready", 32'(TABLE_READY), 32'(0));
        chk("s6_lb", 32'(LB_SUM), 32'(0));
        chk("s6_total", 32'(TOTAL_SUM), 32'(0));
        chk("s6_idx", 32'(LOAD_IDX), 32'(0));
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 64; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 7'($urandom_range(0, 127));
            tick();
            if (i == 62) chk("s6_not_ready_at_63", 32'(TABLE_READY), 32'(0));
        end
        LD_VALID = 1'b0;
        chk("s6_ready_at_64", 32'(TABLE_READY), 32'(1));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
